vga_timing_driver: RTL and testbench

- Generates 640x480@60 Hz VGA timing from the 50 MHz system clock.
- Produces the 25 MHz DAC pixel clock, HS, VS, BLANK_N and SYNC_N.
- Gates the caller's 8-bit RGB to zero outside the visible area.
- Sits between the game renderer, which drives red/green/blue, and the board VGA DAC pins.

---
 rtl/vga_timing_pkg.sv | 47 ++++
 rtl/vga_timing_driver_if.sv | 27 ++
 rtl/vga_sync_counter.sv | 54 +++++
 rtl/vga_timing_driver.sv | 74 +++++++
 tb/tb_vga_timing_driver.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, region bounds and
// the colour-bar table shared by the VGA timing driver.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  typedef logic [9:0] cnt_t;

  localparam cnt_t H_SYNC_END  = cnt_t'(H_SYNC - 1);
  localparam cnt_t H_ACT_START = cnt_t'(H_SYNC + H_BP);
  localparam cnt_t H_ACT_END   = cnt_t'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam cnt_t H_MAX       = cnt_t'(H_TOTAL - 1);

  localparam cnt_t V_SYNC_END  = cnt_t'(V_SYNC - 1);
  localparam cnt_t V_ACT_START = cnt_t'(V_SYNC + V_BP);
  localparam cnt_t V_ACT_END   = cnt_t'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam cnt_t V_MAX       = cnt_t'(V_TOTAL - 1);

  localparam int BAR_W = H_ACTIVE / 8;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] c;
    c = '0;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing_driver_if.sv
// vga_timing_driver_if: renderer RGB in, DAC pin bundle out.
// master = renderer/board side, slave = timing driver.
interface vga_timing_driver_if;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       VGA_CLK;
  logic       VGA_SYNC_N;
  logic       VGA_BLANK_N;
  logic       VGA_HS;
  logic       VGA_VS;

  modport master (
    output red, green, blue,
    input  VGA_R, VGA_G, VGA_B, VGA_CLK,
    input  VGA_SYNC_N, VGA_BLANK_N, VGA_HS, VGA_VS
  );

  modport slave (
    input  red, green, blue,
    output VGA_R, VGA_G, VGA_B, VGA_CLK,
    output VGA_SYNC_N, VGA_BLANK_N, VGA_HS, VGA_VS
  );
endinterface

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: h/v pixel counters and region decode, advanced
// only on pixel-enable. Bar index port exists with VGA_TEST_PATTERN_EN.
module vga_sync_counter
  import vga_timing_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       active
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [2:0] bar
`endif
);

  cnt_t h_cnt;
  cnt_t v_cnt;
  logic h_wrap;

  assign h_wrap = (h_cnt >= H_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
      // out-of-range v recovers on the very next update edge
      if (v_cnt > V_MAX)
        v_cnt <= '0;
      else if (h_wrap)
        v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
    end
  end

  assign hsync  = (h_cnt <= H_SYNC_END);
  assign vsync  = (v_cnt <= V_SYNC_END);
  assign active = (h_cnt >= H_ACT_START) && (h_cnt <= H_ACT_END) &&
                  (v_cnt >= V_ACT_START) && (v_cnt <= V_ACT_END);

`ifdef VGA_TEST_PATTERN_EN
  cnt_t x;
  assign x = h_cnt - H_ACT_START;

  always_comb begin
    bar = '0;
    for (int i = 1; i < 8; i++)
      if (x >= cnt_t'(i * BAR_W)) bar = 3'(i);
  end
`endif

endmodule

// File: rtl/vga_timing_driver.sv
// vga_timing_driver: 640x480@60 VGA timing from a 50 MHz clock.
// Define VGA_TEST_PATTERN_EN to replace renderer RGB with colour bars.
module vga_timing_driver
  import vga_timing_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  vga_timing_driver_if.slave  vga
);

  logic        tog;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic [23:0] pix;
  logic [23:0] rgb_q;
  logic        hs_q;
  logic        vs_q;
  logic        blank_n_q;
`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]  bar;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tog <= 1'b0;
    else        tog <= ~tog;
  end

  vga_sync_counter u_cnt (
    .clk    (clk),
    .reset  (reset),
    .pix_en (tog),
    .hsync  (hsync),
    .vsync  (vsync),
    .active (active)
`ifdef VGA_TEST_PATTERN_EN
    ,
    .bar    (bar)
`endif
  );

  always_comb begin
`ifdef VGA_TEST_PATTERN_EN
    pix = bar_rgb(bar);
`else
    pix = {vga.red, vga.green, vga.blue};
`endif
  end

  // update on VGA_CLK falling so the DAC sees stable data on its rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else if (tog) begin
      hs_q      <= ~hsync;
      vs_q      <= ~vsync;
      blank_n_q <= active;
      rgb_q     <= active ? pix : 24'h0;
    end
  end

  assign vga.VGA_CLK     = tog;
  assign vga.VGA_SYNC_N  = 1'b0;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = blank_n_q;
  assign vga.VGA_R       = rgb_q[23:16];
  assign vga.VGA_G       = rgb_q[15:8];
  assign vga.VGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_driver.sv
// tb_vga_timing_driver: directed checks of reset, sync widths,
// active-area gating and mid-line reset for vga_timing_driver.
module tb_vga_timing_driver;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vga_timing_driver_if vif();

  vga_timing_driver dut (
    .clk   (clk),
    .reset (reset),
    .vga   (vif)
  );

  always #10 clk = ~clk;

  function automatic logic [23:0] exp_pix(input int x);
    logic [23:0] c;
`ifdef VGA_TEST_PATTERN_EN
    case (x / 80)
      0:       c = 24'hFFFFFF;
      1:       c = 24'hFFFF00;
      2:       c = 24'h00FFFF;
      3:       c = 24'h00FF00;
      4:       c = 24'hFF00FF;
      5:       c = 24'hFF0000;
      6:       c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
`else
    c = (x >= 0) ? 24'hAA55FF : 24'h0;
`endif
    return c;
  endfunction

  function automatic logic [23:0] rgb();
    return {vif.VGA_R, vif.VGA_G, vif.VGA_B};
  endfunction

  task automatic restart();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic pclk;
    vif.red   = 8'hAA;
    vif.green = 8'h55;
    vif.blue  = 8'hFF;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({vif.VGA_CLK, vif.VGA_HS, vif.VGA_VS, vif.VGA_BLANK_N,
           vif.VGA_SYNC_N} !== 5'b01100) begin
        errors++;
        $display("FAIL rst_ctl: got %b expected 01100",
                 {vif.VGA_CLK, vif.VGA_HS, vif.VGA_VS,
                  vif.VGA_BLANK_N, vif.VGA_SYNC_N});
      end
      checks++;
      if (rgb() !== 24'h0) begin
        errors++;
        $display("FAIL rst_rgb: got %h expected 000000", rgb());
      end
    end
    reset = 1'b1;
    pclk = vif.VGA_CLK;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (vif.VGA_CLK !== ~pclk) begin
        errors++;
        $display("FAIL clk_toggle: got %b expected %b",
                 vif.VGA_CLK, ~pclk);
      end
      pclk = vif.VGA_CLK;
    end
  endtask

  task automatic test_sync();
    int hf1 = -1, hf2 = -1, hr1 = -1, vf = -1, vr = -1;
    int sync_bad = 0, clk_bad = 0;
    logic phs = 1'b1, pvs = 1'b1, pclk = 1'b0;
    restart();
    for (int n = 1; n <= 3400; n++) begin
      @(negedge clk);
      if (vif.VGA_SYNC_N !== 1'b0) sync_bad++;
      if (vif.VGA_CLK === pclk) clk_bad++;
      pclk = vif.VGA_CLK;
      if (phs === 1'b1 && vif.VGA_HS === 1'b0) begin
        if (hf1 < 0) hf1 = n;
        else if (hf2 < 0) hf2 = n;
      end
      if (phs === 1'b0 && vif.VGA_HS === 1'b1 && hr1 < 0) hr1 = n;
      if (pvs === 1'b1 && vif.VGA_VS === 1'b0 && vf < 0) vf = n;
      if (pvs === 1'b0 && vif.VGA_VS === 1'b1 && vr < 0) vr = n;
      phs = vif.VGA_HS;
      pvs = vif.VGA_VS;
    end
    checks++;
    if (hf1 !== 2) begin
      errors++;
      $display("FAIL hs_first: got %0d expected 2", hf1);
    end
    checks++;
    if (hr1 - hf1 !== 192) begin
      errors++;
      $display("FAIL hs_width: got %0d expected 192", hr1 - hf1);
    end
    checks++;
    if (hf2 - hf1 !== 1600) begin
      errors++;
      $display("FAIL hs_period: got %0d expected 1600", hf2 - hf1);
    end
    checks++;
    if (vf !== 2) begin
      errors++;
      $display("FAIL vs_first: got %0d expected 2", vf);
    end
    checks++;
    if (vr - vf !== 3200) begin
      errors++;
      $display("FAIL vs_width: got %0d expected 3200", vr - vf);
    end
    checks++;
    if (sync_bad !== 0) begin
      errors++;
      $display("FAIL sync_n: got %0d bad samples expected 0",
               sync_bad);
    end
    checks++;
    if (clk_bad !== 0) begin
      errors++;
      $display("FAIL vga_clk: got %0d stuck samples expected 0",
               clk_bad);
    end
  endtask

  task automatic test_active();
    int rise[2] = '{-1, -1};
    int width[2] = '{-1, -1};
    int runs = 0, cur = 0, pix_bad = 0;
    logic pb = 1'b0;
    logic [23:0] exp, first_px = '0, px400 = '0;
    restart();
    for (int n = 1; n <= 59300; n++) begin
      @(negedge clk);
      if (pb === 1'b0 && vif.VGA_BLANK_N === 1'b1) begin
        cur = n;
        if (runs < 2) rise[runs] = n;
      end
      if (pb === 1'b1 && vif.VGA_BLANK_N === 1'b0) begin
        if (runs < 2) width[runs] = n - cur;
        runs++;
      end
      if (vif.VGA_BLANK_N === 1'b1) begin
        exp = exp_pix((n - cur) / 2);
        if (n == cur && runs == 0) first_px = rgb();
        if (runs == 0 && n == cur + 800) px400 = rgb();
      end else begin
        exp = 24'h0;
      end
      if (rgb() !== exp) pix_bad++;
      pb = vif.VGA_BLANK_N;
    end
    checks++;
    if (runs !== 2) begin
      errors++;
      $display("FAIL blank_runs: got %0d expected 2", runs);
    end
    checks++;
    if (rise[0] !== 56290) begin
      errors++;
      $display("FAIL blank_start: got %0d expected 56290", rise[0]);
    end
    checks++;
    if (width[0] !== 1280) begin
      errors++;
      $display("FAIL blank_width0: got %0d expected 1280", width[0]);
    end
    checks++;
    if (width[1] !== 1280) begin
      errors++;
      $display("FAIL blank_width1: got %0d expected 1280", width[1]);
    end
    checks++;
    if (rise[1] - rise[0] !== 1600) begin
      errors++;
      $display("FAIL blank_period: got %0d expected 1600",
               rise[1] - rise[0]);
    end
    checks++;
    if (first_px !== exp_pix(0)) begin
      errors++;
      $display("FAIL first_px: got %h expected %h",
               first_px, exp_pix(0));
    end
    checks++;
    if (px400 !== exp_pix(400)) begin
      errors++;
      $display("FAIL px400: got %h expected %h", px400, exp_pix(400));
    end
    checks++;
    if (pix_bad !== 0) begin
      errors++;
      $display("FAIL rgb_gate: got %0d bad samples expected 0",
               pix_bad);
    end
  endtask

  task automatic test_reset_mid_line();
    restart();
    repeat (801) @(negedge clk);
    checks++;
    if ({vif.VGA_CLK, vif.VGA_VS} !== 2'b10) begin
      errors++;
      $display("FAIL mid_pre: got %b expected 10",
               {vif.VGA_CLK, vif.VGA_VS});
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({vif.VGA_CLK, vif.VGA_HS, vif.VGA_VS, vif.VGA_BLANK_N}
        !== 4'b0110) begin
      errors++;
      $display("FAIL mid_async: got %b expected 0110",
               {vif.VGA_CLK, vif.VGA_HS, vif.VGA_VS,
                vif.VGA_BLANK_N});
    end
    checks++;
    if (rgb() !== 24'h0) begin
      errors++;
      $display("FAIL mid_rgb: got %h expected 000000", rgb());
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (vif.VGA_HS !== 1'b1) begin
      errors++;
      $display("FAIL mid_hs1: got %b expected 1", vif.VGA_HS);
    end
    @(negedge clk);
    checks++;
    if ({vif.VGA_HS, vif.VGA_VS, vif.VGA_CLK} !== 3'b000) begin
      errors++;
      $display("FAIL mid_hs2: got %b expected 000",
               {vif.VGA_HS, vif.VGA_VS, vif.VGA_CLK});
    end
  endtask

  initial begin
    vif.red   = 8'h00;
    vif.green = 8'h00;
    vif.blue  = 8'h00;
    test_reset();
    test_sync();
    test_active();
    test_reset_mid_line();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
